// File: rtl/turbo_qpp_param_gen.sv
// Turbo decoder input-parameter generator.
// Checks K/P, derives sub-block and window sizes, and fetches f1/f2 from an external ROM.
// It then computes every sub-block interleaver start address PI(j*S) with a shared
// serial modular multiplier and a second-order difference recurrence.
module turbo_qpp_param_gen #(
    parameter int MAX_PD_LOG2 = 4,
    parameter int WIN_LOG2    = 6,
    parameter int ROM_LAT     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Start_Cmp,
    input  logic [12:0]            CB_length,
    input  logic [MAX_PD_LOG2:0]   Parallel_degree,
    output logic                   rom_rd_en,
    output logic [7:0]             rom_addr,
    input  logic [18:0]            rom_data,
    output logic                   busy,
    output logic [12:0]            BLOCK_SIZE,
    output logic [WIN_LOG2:0]      window_size,
    output logic [WIN_LOG2-1:0]    r,
    output logic [12-WIN_LOG2:0]   q_up,
    output logic [8:0]             f1,
    output logic [9:0]             f2,
    output logic                   init_valid,
    output logic [MAX_PD_LOG2-1:0] init_idx,
    output logic [12:0]            init_addr,
    output logic                   param_err,
    output logic                   start_decode
);

    // Shared step counter: ROM latency wait, 13 multiply bits, and P stream beats.
    localparam int CNT_W = 8;
    localparam int QW    = 13 - WIN_LOG2;
    localparam logic [WIN_LOG2:0] W_VAL = {1'b1, {WIN_LOG2{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_ROM, S_MUL1, S_MUL2, S_MUL3, S_COMB, S_STREAM, S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [12:0]          k_lat;
    logic [MAX_PD_LOG2:0] p_lat;
    logic [3:0]           log2p;
    logic [12:0]          s_calc, s_red;
    logic                 chk_err, p_onehot;
    logic [12:0]          mul_a, mul_acc, mul_nxt;
    logic [3:0]           bidx;
    logic                 mul_bit, mul_last, stream_last;
    logic [12:0]          t1, t2, t3, d_inc, c1, addr;

    // (a + b) mod k for a, b < k: one conditional subtract
    function automatic logic [12:0] mod_add(input logic [12:0] a, input logic [12:0] b,
                                            input logic [12:0] k);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, k}) ? 13'(s - {1'b0, k}) : s[12:0];
    endfunction

    // An operand equal to K is congruent to 0 (happens for S when P = 1)
    function automatic logic [12:0] mod_red(input logic [12:0] a, input logic [12:0] k);
        return (a == k) ? 13'd0 : a;
    endfunction

    function automatic logic k_legal(input logic [12:0] k);
        logic ok;
        ok = 1'b0;
        if (k >= 13'd40 && k <= 13'd512)          ok = (k[2:0] == 3'd0);
        else if (k >= 13'd528 && k <= 13'd1024)   ok = (k[3:0] == 4'd0);
        else if (k >= 13'd1056 && k <= 13'd2048)  ok = (k[4:0] == 5'd0);
        else if (k >= 13'd2112 && k <= 13'd6144)  ok = (k[5:0] == 6'd0);
        return ok;
    endfunction

    // Piecewise-linear map of the legal K ladder onto ROM rows 0..187
    function automatic logic [7:0] rom_index(input logic [12:0] k);
        if (k <= 13'd512)       return 8'((k >> 3) - 13'd5);
        else if (k <= 13'd1024) return 8'((k >> 4) + 13'd27);
        else if (k <= 13'd2048) return 8'((k >> 5) + 13'd59);
        else                    return 8'((k >> 6) + 13'd91);
    endfunction

    // Decode latched P: one-hot test, log2, sub-block size and the combined error flag
    always_comb begin
        log2p = 4'd0;
        for (int i = 0; i <= MAX_PD_LOG2; i++) begin
            if (p_lat[i]) log2p = 4'(i);
        end
        p_onehot = (p_lat != '0) && ((p_lat & (p_lat - 1'b1)) == '0);
        s_calc   = k_lat >> log2p;
        chk_err  = !k_legal(k_lat) || !p_onehot ||
                   ((k_lat & (13'(p_lat) - 13'd1)) != 13'd0);
    end

    // Multiplier operand select and one MSB-first double-and-add step
    always_comb begin
        mul_a = 13'd0;
        case (state)
            S_MUL1:  mul_a = mod_red(13'(f2), k_lat);
            S_MUL2:  mul_a = t1;
            S_MUL3:  mul_a = mod_red(13'(f1), k_lat);
            default: mul_a = 13'd0;
        endcase
        s_red       = mod_red(BLOCK_SIZE, k_lat);
        bidx        = 4'd12 - cnt[3:0];
        mul_bit     = s_red[bidx];
        mul_nxt     = mod_add(mod_add(mul_acc, mul_acc, k_lat), mul_bit ? mul_a : 13'd0, k_lat);
        mul_last    = (cnt == CNT_W'(12));
        stream_last = (cnt == CNT_W'(p_lat - 1'b1));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (Start_Cmp) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = chk_err ? S_IDLE : S_ROM;
            S_ROM:    if (cnt == CNT_W'(ROM_LAT)) state_nxt = S_MUL1;
            S_MUL1:   if (mul_last) state_nxt = S_MUL2;
            S_MUL2:   if (mul_last) state_nxt = S_MUL3;
            S_MUL3:   if (mul_last) state_nxt = S_COMB;
            S_COMB:   state_nxt = S_STREAM;
            S_STREAM: if (stream_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register and per-state step counter (restarts on every state change)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state || state == S_IDLE) ? '0 : cnt + 1'b1;
        end
    end

    // Visible parameter registers: cleared by reset, updated by CHECK and ROM capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr     <= '0;
            BLOCK_SIZE   <= '0;
            window_size  <= '0;
            r            <= '0;
            q_up         <= '0;
            f1           <= '0;
            f2           <= '0;
            param_err    <= 1'b0;
            start_decode <= 1'b0;
        end else begin
            start_decode <= (state == S_DONE);
            if (state == S_IDLE && Start_Cmp) param_err <= 1'b0;
            if (state == S_CHECK) begin
                if (chk_err) begin
                    param_err <= 1'b1;
                end else begin
                    BLOCK_SIZE  <= s_calc;
                    r           <= s_calc[WIN_LOG2-1:0];
                    q_up        <= QW'(s_calc >> WIN_LOG2) + QW'(s_calc[WIN_LOG2-1:0] != '0);
                    window_size <= W_VAL;
                    rom_addr    <= rom_index(k_lat);
                end
            end
            if (state == S_ROM && cnt == CNT_W'(ROM_LAT)) begin
                f2 <= rom_data[18:9];
                f1 <= rom_data[8:0];
            end
        end
    end

    // Arithmetic datapath: input latch, serial products, difference recurrence
    always_ff @(posedge clk) begin
        if (state == S_IDLE && Start_Cmp) begin
            k_lat <= CB_length;
            p_lat <= Parallel_degree;
        end
        if (state inside {S_MUL1, S_MUL2, S_MUL3}) mul_acc <= mul_last ? 13'd0 : mul_nxt;
        else                                       mul_acc <= 13'd0;
        if (mul_last) begin
            case (state)
                S_MUL1:  t1 <= mul_nxt;
                S_MUL2:  t2 <= mul_nxt;
                S_MUL3:  t3 <= mul_nxt;
                default: ;
            endcase
        end
        // PI((j+1)S) - PI(jS) = f1*S + f2*S^2*(2j+1): first difference D, step C1 = 2*f2*S^2
        if (state == S_COMB) begin
            d_inc <= mod_add(t3, t2, k_lat);
            c1    <= mod_add(t2, t2, k_lat);
            addr  <= 13'd0;
        end
        if (state == S_STREAM) begin
            addr  <= mod_add(addr, d_inc, k_lat);
            d_inc <= mod_add(d_inc, c1, k_lat);
        end
    end

    assign busy       = (state != S_IDLE);
    assign rom_rd_en  = (state == S_ROM) && (cnt == '0);
    assign init_valid = (state == S_STREAM);
    assign init_idx   = init_valid ? cnt[MAX_PD_LOG2-1:0] : '0;
    assign init_addr  = init_valid ? addr : 13'd0;

endmodule

// File: tb/tb_turbo_qpp_param_gen.sv
// Scoreboard bench for turbo_qpp_param_gen: stimulus queues expected ROM reads, start
// address beats and the start_decode event; a negedge monitor pops and compares them.
module tb_turbo_qpp_param_gen;
    localparam int MAX_PD_LOG2 = 4;
    localparam int WIN_LOG2    = 6;
    localparam int ROM_LAT     = 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   Start_Cmp = 1'b0;
    logic [12:0]            CB_length = '0;
    logic [MAX_PD_LOG2:0]   Parallel_degree = '0;
    logic                   rom_rd_en;
    logic [7:0]             rom_addr;
    logic [18:0]            rom_data;
    logic                   busy;
    logic [12:0]            BLOCK_SIZE;
    logic [WIN_LOG2:0]      window_size;
    logic [WIN_LOG2-1:0]    r;
    logic [12-WIN_LOG2:0]   q_up;
    logic [8:0]             f1;
    logic [9:0]             f2;
    logic                   init_valid;
    logic [MAX_PD_LOG2-1:0] init_idx;
    logic [12:0]            init_addr;
    logic                   param_err;
    logic                   start_decode;

    turbo_qpp_param_gen #(.MAX_PD_LOG2(MAX_PD_LOG2), .WIN_LOG2(WIN_LOG2), .ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .reset(reset), .Start_Cmp(Start_Cmp), .CB_length(CB_length),
        .Parallel_degree(Parallel_degree), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy), .BLOCK_SIZE(BLOCK_SIZE), .window_size(window_size),
        .r(r), .q_up(q_up), .f1(f1), .f2(f2), .init_valid(init_valid), .init_idx(init_idx),
        .init_addr(init_addr), .param_err(param_err), .start_decode(start_decode)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; int addr; } beat_t;
    typedef struct { longint cyc; int s; int r; int q; int f1; int f2; } done_t;

    int     exp_rom[$];
    beat_t  exp_beat[$];
    done_t  exp_done[$];
    int     n_cmp = 0;
    int     n_err = 0;
    bit     done_seen = 1'b0;
    beat_t  mon_b;
    done_t  mon_d;

    // QPP coefficient table (only the rows the tests touch are meaningful)
    function automatic logic [18:0] rom_lookup(input logic [7:0] idx);
        case (idx)
            8'd0:          return {10'd10, 9'd3};
            8'd90:         return {10'd84, 9'd55};
            8'd91, 8'd123: return {10'd64, 9'd31};
            8'd187:        return {10'd480, 9'd263};
            default:       return {10'd4, 9'd7};
        endcase
    endfunction

    // ROM with ROM_LAT cycles of read latency
    logic [18:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_rd_en ? rom_lookup(rom_addr) : 19'h0;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every DUT output event must match the head of its queue
    always @(negedge clk) begin
        if (reset) begin
            if (rom_rd_en) begin
                if (exp_rom.size() == 0) chk("unexpected rom_rd_en", 1, 0);
                else chk("rom_addr", rom_addr, exp_rom.pop_front());
            end
            if (init_valid) begin
                if (exp_beat.size() == 0) chk("unexpected init_valid", 1, 0);
                else begin
                    mon_b = exp_beat.pop_front();
                    chk("init_idx", init_idx, mon_b.idx);
                    chk("init_addr", init_addr, mon_b.addr);
                end
            end
            if (start_decode) begin
                if (exp_done.size() == 0) chk("unexpected start_decode", 1, 0);
                else begin
                    mon_d = exp_done.pop_front();
                    chk("start_decode cycle", cyc, mon_d.cyc);
                    chk("BLOCK_SIZE", BLOCK_SIZE, mon_d.s);
                    chk("r", r, mon_d.r);
                    chk("q_up", q_up, mon_d.q);
                    chk("f1", f1, mon_d.f1);
                    chk("f2", f2, mon_d.f2);
                    chk("window_size", window_size, 64);
                    chk("param_err at done", param_err, 0);
                    chk("busy at done", busy, 0);
                    done_seen = 1'b1;
                end
            end
        end
    end

    // Queue expectations for one legal run and issue Start_Cmp; e0 is the accepting edge
    task automatic issue(input int k, input int pd, input int e_rom, input int e_s,
                         input int e_r, input int e_q, output longint e0);
        logic [18:0] w;
        int f1v, f2v;
        longint x, a;
        @(negedge clk);
        e0  = cyc + 1;
        w   = rom_lookup(8'(e_rom));
        f1v = int'(w[8:0]);
        f2v = int'(w[18:9]);
        exp_rom.push_back(e_rom);
        for (int j = 0; j < pd; j++) begin
            x = longint'(j) * e_s;
            a = (longint'(f1v) * x + longint'(f2v) * x * x) % k;
            exp_beat.push_back('{j, int'(a)});
        end
        exp_done.push_back('{e0 + 43 + ROM_LAT + pd, e_s, e_r, e_q, f1v, f2v});
        done_seen       = 1'b0;
        Start_Cmp       = 1'b1;
        CB_length       = k[12:0];
        Parallel_degree = pd[MAX_PD_LOG2:0];
        @(negedge clk);
        Start_Cmp = 1'b0;
        chk("busy after accept", busy, 1);
        chk("param_err cleared on accept", param_err, 0);
    endtask

    // Wait (bounded) for start_decode; optionally fire a second Start_Cmp during MUL2
    task automatic wait_done(input longint e0, input bit dbl);
        for (int i = 0; i < 300 && !done_seen; i++) begin
            @(negedge clk);
            if (dbl && cyc == e0 + 20) begin
                Start_Cmp       = 1'b1;
                CB_length       = 13'd48;
                Parallel_degree = 5'b00001;
            end else begin
                Start_Cmp = 1'b0;
            end
        end
        Start_Cmp = 1'b0;
        if (!done_seen) chk("timeout waiting start_decode", 0, 1);
        @(negedge clk);
        chk("busy idle after run", busy, 0);
        chk("start_decode single pulse", start_decode, 0);
        chk("beats left over", exp_beat.size(), 0);
        chk("rom reads left over", exp_rom.size(), 0);
    endtask

    task automatic run_err(input string nm, input int k, input int pd);
        @(negedge clk);
        Start_Cmp       = 1'b1;
        CB_length       = k[12:0];
        Parallel_degree = pd[MAX_PD_LOG2:0];
        @(negedge clk);
        Start_Cmp = 1'b0;
        chk({nm, " busy in CHECK"}, busy, 1);
        @(negedge clk);
        chk({nm, " param_err"}, param_err, 1);
        chk({nm, " busy after CHECK"}, busy, 0);
        repeat (60) @(negedge clk);
        chk({nm, " param_err held"}, param_err, 1);
    endtask

    function automatic logic any_out();
        return |{rom_rd_en, rom_addr, busy, BLOCK_SIZE, window_size, r, q_up, f1, f2,
                 init_valid, init_idx, init_addr, param_err, start_decode};
    endfunction

    initial begin
        longint e0;
        repeat (3) @(negedge clk);
        chk("outputs zero in reset", any_out(), 0);
        reset = 1'b1;
        @(negedge clk);

        issue(40, 4, 0, 10, 10, 1, e0);        wait_done(e0, 1'b0);
        issue(6144, 8, 187, 768, 0, 12, e0);   wait_done(e0, 1'b0);
        issue(1008, 8, 90, 126, 62, 2, e0);    wait_done(e0, 1'b0);
        issue(1024, 2, 91, 512, 0, 8, e0);     wait_done(e0, 1'b0);
        issue(2048, 16, 123, 128, 0, 2, e0);   wait_done(e0, 1'b0);

        run_err("K44", 44, 4);
        run_err("P0b00110", 40, 6);
        run_err("K40P16", 40, 16);

        issue(40, 4, 0, 10, 10, 1, e0);        wait_done(e0, 1'b1);
        issue(40, 1, 0, 40, 40, 1, e0);        wait_done(e0, 1'b0);

        issue(40, 4, 0, 10, 10, 1, e0);
        while (cyc < e0 + 44) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("outputs zero on mid-stream reset", any_out(), 0);
        exp_rom.delete();
        exp_beat.delete();
        exp_done.delete();
        @(negedge clk);
        reset = 1'b1;
        issue(1008, 8, 90, 126, 62, 2, e0);    wait_done(e0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end
endmodule
